// File: rtl/step_seq_pkg.sv
// Shared encodings and defaults for the programmable step sequencer.
package step_seq_pkg;

  localparam int unsigned SEQ_DEFAULT_DIV   = 50000;
  localparam int unsigned SEQ_DEFAULT_STEPS = 16;

  typedef enum logic [1:0] {
    SEQ_MODE_LOOP     = 2'd0,
    SEQ_MODE_ONESHOT  = 2'd1,
    SEQ_MODE_PINGPONG = 2'd2,
    SEQ_MODE_RSVD     = 2'd3
  } seq_mode_e;

  typedef enum logic {
    SEQ_DIR_UP   = 1'b0,
    SEQ_DIR_DOWN = 1'b1
  } seq_dir_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned seq_cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_prescaler.sv
// Divides clk by DIV into a one-clk tick; synchronous clear, enable freezes the count.
module seq_prescaler
  import step_seq_pkg::*;
#(
  parameter int unsigned DIV = SEQ_DEFAULT_DIV
) (
  input  logic i_clk,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned    CW   = seq_cnt_width(DIV);
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_tick = i_en && !i_clear && (r_cnt == LAST);

endmodule

// File: rtl/step_sequencer.sv
// Multi-step sequencer: per-step dwell table, loop/one-shot/ping-pong walk, step-start pulse.
// Optional STEP_SEQ_HOLD_EN adds i_hold, which freezes prescaler and step timing.
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int unsigned DIV       = SEQ_DEFAULT_DIV,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DLY_WIDTH = 8,
  parameter int unsigned STEPS     = SEQ_DEFAULT_STEPS
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_run,
  input  logic [1:0]           i_mode,
  input  logic [WIDTH-1:0]     i_max_cnt,
  input  logic                 i_wr_en,
  input  logic [WIDTH-1:0]     i_wr_addr,
  input  logic [DLY_WIDTH-1:0] i_wr_data,
`ifdef STEP_SEQ_HOLD_EN
  input  logic                 i_hold,
`endif
  output logic [WIDTH-1:0]     o_index,
  output logic                 o_pulse,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned      AW        = seq_cnt_width(STEPS);
  localparam logic [WIDTH-1:0] LAST_STEP = WIDTH'(STEPS - 1);

  logic [DLY_WIDTH-1:0] r_table [STEPS];

  logic [WIDTH-1:0]     r_index, w_index_nxt;
  logic [DLY_WIDTH-1:0] r_dly, w_dly_nxt;
  seq_dir_e             r_dir, w_dir_nxt;
  logic                 r_done, w_done_nxt;

  logic                 w_clear;
  logic                 w_en;
  logic                 w_tick;
  logic [WIDTH-1:0]     w_last;
  logic [DLY_WIDTH-1:0] w_dwell;

  // Table is not reset; run/reset only rewind the walk.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && (32'(i_wr_addr) < STEPS)) begin
      r_table[i_wr_addr[AW-1:0]] <= i_wr_data;
    end
  end

  assign w_dwell = r_table[r_index[AW-1:0]];
  assign w_last  = (i_max_cnt > LAST_STEP) ? LAST_STEP : i_max_cnt;
  assign w_clear = i_reset || !i_run || r_done;

`ifdef STEP_SEQ_HOLD_EN
  assign w_en = !i_hold;
`else
  assign w_en = 1'b1;
`endif

  seq_prescaler #(.DIV(DIV)) u_prescaler (
    .i_clk   (i_clk),
    .i_clear (w_clear),
    .i_en    (w_en),
    .o_tick  (w_tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_run) begin
      r_index <= '0;
      r_dly   <= '0;
      r_dir   <= SEQ_DIR_UP;
      r_done  <= 1'b0;
    end else begin
      r_index <= w_index_nxt;
      r_dly   <= w_dly_nxt;
      r_dir   <= w_dir_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_index_nxt = r_index;
    w_dly_nxt   = r_dly;
    w_dir_nxt   = r_dir;
    w_done_nxt  = r_done;
    if (w_tick) begin
      if (r_dly >= w_dwell) begin
        w_dly_nxt = '0;
        case (seq_mode_e'(i_mode))
          SEQ_MODE_ONESHOT: begin
            if (r_index == w_last)     w_done_nxt  = 1'b1;
            else if (r_index > w_last) w_index_nxt = '0;
            else                       w_index_nxt = r_index + WIDTH'(1);
          end
          SEQ_MODE_PINGPONG: begin
            // An index stranded above a lowered limit walks back down.
            if (r_dir == SEQ_DIR_UP) begin
              if (r_index < w_last) begin
                w_index_nxt = r_index + WIDTH'(1);
              end else if (r_index != '0) begin
                w_index_nxt = r_index - WIDTH'(1);
                w_dir_nxt   = SEQ_DIR_DOWN;
              end
            end else begin
              if (r_index != '0) begin
                w_index_nxt = r_index - WIDTH'(1);
              end else begin
                w_dir_nxt   = SEQ_DIR_UP;
                w_index_nxt = (w_last != '0) ? WIDTH'(1) : '0;
              end
            end
          end
          default: begin
            w_index_nxt = (r_index >= w_last) ? '0 : r_index + WIDTH'(1);
          end
        endcase
      end else begin
        w_dly_nxt = r_dly + DLY_WIDTH'(1);
      end
    end
  end

  assign o_index = r_index;
  assign o_pulse = w_tick && (r_dly == '0);
  assign o_busy  = i_run && !r_done;
  assign o_done  = r_done;

endmodule
